// File: rtl/com_pkg.sv
// Shared host-bus definitions: default widths and the 2-bit state encoding
// used by the result unloader and by the processor top's state port.
package com_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LEN_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/unloader_checksum.sv
// Running modulo-2^DATA_W sum of streamed result words, cleared while idle.
module unloader_checksum #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_acc_en,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_sum
);

    logic [DATA_W-1:0] r_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_acc_en) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/result_unloader.sv
// Drains a block of result words from data memory onto the host output bus.
// Define UNLOADER_CHECKSUM_EN to append a running-sum checksum word.
module result_unloader #(
    parameter int unsigned DATA_W = com_pkg::DATA_W,
    parameter int unsigned ADDR_W = com_pkg::ADDR_W,
    parameter int unsigned LEN_W  = com_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] com_data_out,
    output logic              output_write_start,
    output logic              output_write_done,
    output logic [1:0]        state
);

    import com_pkg::*;

    state_e            r_state;
    logic [LEN_W-1:0]  r_rd_left;
    logic [LEN_W-1:0]  r_words_left;
    logic              r_rd_vld;
    logic [DATA_W-1:0] w_sum;

`ifdef UNLOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
    logic w_clr;

    assign w_clr = (r_state == ST_IDLE);

    unloader_checksum #(.DATA_W(DATA_W)) u_checksum (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_clr),
        .i_acc_en (r_rd_vld),
        .i_data   (mem_rd_data),
        .o_sum    (w_sum)
    );
`else
    localparam bit CK_EN = 1'b0;
    assign w_sum = '0;
`endif

    assign state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= ST_IDLE;
            r_rd_left          <= '0;
            r_words_left       <= '0;
            r_rd_vld           <= 1'b0;
            mem_rd_en          <= 1'b0;
            mem_addr           <= '0;
            com_data_out       <= '0;
            output_write_start <= 1'b0;
            output_write_done  <= 1'b0;
        end else begin
            // Issue side: one read per clk until the last address has gone out
            if (mem_rd_en) begin
                if (r_rd_left == '0) begin
                    mem_rd_en <= 1'b0;
                end else begin
                    mem_addr  <= mem_addr + ADDR_W'(1);
                    r_rd_left <= r_rd_left - LEN_W'(1);
                end
            end
            // Memory answers one clk after the strobe, so data lines up one clk behind it
            r_rd_vld <= mem_rd_en;

            case (r_state)
                ST_IDLE: begin
                    output_write_start <= 1'b0;
                    output_write_done  <= 1'b0;
                    if (start) begin
                        if (length != '0) begin
                            mem_rd_en    <= 1'b1;
                            mem_addr     <= base_addr;
                            r_rd_left    <= length - LEN_W'(1);
                            r_words_left <= length;
                            r_state      <= ST_FETCH;
                        end else begin
                            com_data_out       <= '0;
                            output_write_start <= CK_EN;
                            output_write_done  <= 1'b1;
                            r_state            <= ST_DONE;
                        end
                    end
                end
                ST_FETCH, ST_STREAM: begin
                    if (r_rd_vld) begin
                        com_data_out       <= mem_rd_data;
                        output_write_start <= 1'b1;
                        output_write_done  <= !CK_EN && (r_words_left == LEN_W'(1));
                        r_words_left       <= r_words_left - LEN_W'(1);
                        r_state            <= ST_STREAM;
                    end else if (r_state == ST_STREAM) begin
                        // Checksum trails the data; a raised done marks it as already sent
                        if (CK_EN && !output_write_done) begin
                            com_data_out       <= w_sum;
                            output_write_start <= 1'b1;
                            output_write_done  <= 1'b1;
                        end else begin
                            output_write_start <= 1'b0;
                            output_write_done  <= 1'b0;
                            r_state            <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    output_write_start <= 1'b0;
                    output_write_done  <= 1'b0;
                    r_state            <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_unloader.sv
// Self-checking bench for result_unloader: directed and randomized transfers
// compared cycle by cycle against a timeline model of the output handshake.
module tb_result_unloader;

`ifdef UNLOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] length = '0;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_rd_data = '0;
    logic [15:0] com_data_out;
    logic        output_write_start;
    logic        output_write_done;
    logic [1:0]  state;

    logic [15:0] mem [0:65535];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Synchronous-read memory: data appears one clk after the strobe edge
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    result_unloader dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .base_addr          (base_addr),
        .length             (length),
        .mem_rd_en          (mem_rd_en),
        .mem_addr           (mem_addr),
        .mem_rd_data        (mem_rd_data),
        .com_data_out       (com_data_out),
        .output_write_start (output_write_start),
        .output_write_done  (output_write_done),
        .state              (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " rd_en"}, 32'(mem_rd_en), 32'd0);
        chk({nm, " addr"},  32'(mem_addr), 32'd0);
        chk({nm, " data"},  32'(com_data_out), 32'd0);
        chk({nm, " ows"},   32'(output_write_start), 32'd0);
        chk({nm, " done"},  32'(output_write_done), 32'd0);
        chk({nm, " state"}, 32'(state), 32'd0);
    endtask

    // Runs one transfer; timeline offset j counts edges after the start edge T.
    // rs_j: re-pulse start after offset j; rst_j: assert reset after offset j (-1 = never).
    task automatic run_xfer(input string nm, input logic [15:0] b, input int len,
                            input int rs_j, input int rst_j);
        int nstream, s0, last, endj, k;
        logic [15:0] sum, hold, w;
        bit rd_e, ows_e, done_e;
        logic [1:0] st_e;
        string t;
        nstream = len + CK;
        s0      = (len == 0) ? 0 : 2;
        last    = s0 + nstream - 1;
        endj    = (len == 0) ? 1 : last + 2;
        sum     = '0;
        hold    = '0;
        @(negedge clk);
        start = 1'b1; base_addr = b; length = 16'(len);
        for (int j = 0; j <= endj + 2; j++) begin
            @(negedge clk);
            start = 1'b0;
            t = $sformatf("%s j=%0d", nm, j);
            rd_e = (len > 0) && (j < len);
            chk({t, " rd_en"}, 32'(mem_rd_en), 32'(rd_e));
            if (rd_e) chk({t, " addr"}, 32'(mem_addr), 32'(16'(b + 16'(j))));
            ows_e  = (nstream > 0) && (j >= s0) && (j <= last);
            done_e = (nstream > 0) ? (j == last) : (j == 0);
            chk({t, " ows"},  32'(output_write_start), 32'(ows_e));
            chk({t, " done"}, 32'(output_write_done), 32'(done_e));
            if (ows_e) begin
                k = j - s0;
                if (k < len) begin
                    w   = mem[16'(b + 16'(k))];
                    sum = sum + w;
                end else begin
                    w = sum;
                end
                hold = w;
                chk({t, " data"}, 32'(com_data_out), 32'(w));
            end else if (len == 0 || j > last) begin
                chk({t, " data_hold"}, 32'(com_data_out), 32'(hold));
            end
            if (len == 0)          st_e = (j == 0) ? 2'd3 : 2'd0;
            else if (j < 2)        st_e = 2'd1;
            else if (j <= last)    st_e = 2'd2;
            else if (j == last+1)  st_e = 2'd3;
            else                   st_e = 2'd0;
            chk({t, " state"}, 32'(state), 32'(st_e));
            if (j == rs_j) begin
                start = 1'b1; base_addr = ~b; length = 16'd5;
            end
            if (j == rst_j) begin
                rst_n = 1'b0;
                #1;
                chk_all_zero({t, " async_rst"});
                @(negedge clk);
                chk_all_zero({t, " in_rst"});
                rst_n = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rb;
        int rl;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        mem[16'h0010] = 16'd5; mem[16'h0011] = 16'd6;
        mem[16'h0012] = 16'd7; mem[16'h0013] = 16'd8;
        run_xfer("basic4", 16'h0010, 4, -1, -1);
        run_xfer("len0", 16'h1234, 0, -1, -1);
        run_xfer("wrap3", 16'hFFFE, 3, -1, -1);
        run_xfer("restart8", 16'h0200, 8, 4, -1);
        run_xfer("reset6", 16'h0300, 6, -1, 4);
        run_xfer("after_rst", 16'h0400, 6, -1, -1);
        mem[16'h0500] = 16'hFFFF; mem[16'h0501] = 16'h0002;
        run_xfer("cksum2", 16'h0500, 2, -1, -1);
        run_xfer("len1", 16'h0777, 1, -1, -1);

        for (int n = 0; n < 10; n++) begin
            rb = ($urandom_range(0, 1) == 1) ? 16'(16'hFFF8 + 16'($urandom_range(0, 7)))
                                             : 16'($urandom);
            rl = $urandom_range(0, 12);
            run_xfer($sformatf("rand%0d", n), rb, rl, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_unloader.md
Name: result_unloader

Overview:
- Downstream drain stage of the multi-core processor: once the cores finish, it reads a block of result words from data memory and streams them on the 16-bit host communication bus.
- It drives com_data_out, output_write_start and output_write_done, the same host-side output handshake the processor top presents.
- It has no backpressure: the host consumes one word per clk while output_write_start is high.

Parameters:
- DATA_W, 16, width of memory words and of com_data_out.
- ADDR_W, 16, data-memory address width.
- LEN_W, 16, width of the length input.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse from core control meaning "all cores done". Only sampled in IDLE.
- base_addr  input  ADDR_W  first result address. Sampled with start.
- length  input  LEN_W  number of result words. Sampled with start.
- mem_rd_en  output  1  data-memory read strobe, registered.
- mem_addr  output  ADDR_W  data-memory read address, registered.
- mem_rd_data  input  DATA_W  read data. Valid exactly 1 clk after the edge at which mem_rd_en/mem_addr were presented.
- com_data_out  output  DATA_W  streamed word, registered.
- output_write_start  output  1  high on every cycle com_data_out holds a valid word.
- output_write_done  output  1  high together with the final valid word.
- state  output  2  current FSM state: IDLE=0, FETCH=1, STREAM=2, DONE=3.

Behaviour:
- Reset (rst_n low, any time, including mid-stream):
  - All outputs go to 0 and the FSM goes to IDLE immediately.
  - In-flight reads are discarded; no partial stream resumes after reset.
- IDLE:
  - start=1 and length>0 at edge T: latch base_addr and length; mem_rd_en<=1, mem_addr<=base_addr; go to FETCH.
  - start=1 and length=0: go to DONE. output_write_done pulses for one cycle with output_write_start=0 and com_data_out=0.
- FETCH/STREAM issue side:
  - One read is issued per clk.
  - mem_addr increments modulo 2^ADDR_W, so addresses wrap past all-ones to 0.
  - mem_rd_en deasserts on the edge after the read of address base+length-1 is issued.
- Data side:
  - Word k (0-based) is registered into com_data_out at edge T+2+k, with output_write_start=1.
  - The FSM enters STREAM at edge T+2.
  - Latency from the start edge to the first visible word is 2 clk. Throughput is 1 word/clk.
- Last word (k=length-1):
  - output_write_done=1 in the same cycle as the last word.
  - At the next edge, output_write_start and output_write_done <=0, com_data_out holds its value, and the FSM goes to DONE.
- DONE: lasts one cycle, then returns to IDLE.
- start asserted in any state other than IDLE is ignored. It is not queued.
- length=1: output_write_start and output_write_done are both high for the single word at T+2.
- Maximum length is 2^LEN_W-1. The internal word counter is LEN_W bits and never overflows.

Optional Feature:
- Macro: UNLOADER_CHECKSUM_EN.
- When defined:
  - A DATA_W-bit running sum (mod 2^DATA_W) of every streamed word is kept.
  - The sum is emitted as one extra word after the data, with output_write_start=1.
  - output_write_done moves from the last data word to the checksum word.
  - The stream is length+1 cycles long.
  - length=0 emits a single checksum word of 0 with output_write_done=1.
- When undefined: there is no accumulator and no extra word; behaviour is as above.

Decomposition:
- Shared package com_pkg holds:
  - DATA_W and ADDR_W defaults.
  - The 2-bit state encodings ST_IDLE, ST_FETCH, ST_STREAM, ST_DONE. The processor top reuses these for its own state port.
- One natural sub-module, unloader_checksum: accumulator with clear and accumulate enables. It is instantiated only under UNLOADER_CHECKSUM_EN.

Test Plan:
1. Memory preloaded with addr 0x0010..0x0013 = 5,6,7,8; base=0x0010, length=4, start at T:
   - com_data_out = 5,6,7,8 at T+2..T+5 with output_write_start=1.
   - output_write_done=1 only at T+5; state returns to 0 at T+7.
2. length=0:
   - Exactly one cycle of output_write_done=1 with output_write_start=0.
   - No mem_rd_en pulse.
3. base=0xFFFE, length=3:
   - mem_addr sequence is 0xFFFE, 0xFFFF, 0x0000.
   - Three words are streamed in that order.
4. start re-pulsed during STREAM of a length-8 transfer:
   - The transfer completes unchanged with 8 words.
   - No second transfer starts.
5. rst_n driven low at word 2 of a length-6 transfer:
   - All outputs read 0 asynchronously and state=0.
   - A new start after reset streams from its own base.
6. With UNLOADER_CHECKSUM_EN, data 0xFFFF,0x0002:
   - Third word is 0x0001 with output_write_done=1.
   - Second word has output_write_done=0.
